// File: rtl/pll_reset_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_MEM   = 3'd2,
        REL_CORE  = 3'd3,
        RUN       = 3'd4,
        SOFT      = 3'd5
    } seq_state_t;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_STAGE_GAP          = 16;
    localparam int unsigned DEF_SOFT_CYCLES        = 8;

    localparam int unsigned SEQ_CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// Staged reset release after PLL lock, soft core/peripheral reset, and
// clock-enable strobes derived from the core reset release.
//
// state     | meaning
// WAIT_LOCK | all resets held, waiting for synchronized lock
// STABLE    | lock seen, counting stability cycles
// REL_MEM   | memory reset released, waiting a stage gap
// REL_CORE  | core reset released, waiting a stage gap
// RUN       | all resets released, ready
// SOFT      | soft reset holding core and peripherals
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned STAGE_GAP          = DEF_STAGE_GAP,
    parameter int unsigned SOFT_CYCLES        = DEF_SOFT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic soft_rst_req,
    output logic rst_mem,
    output logic rst_core,
    output logic rst_periph,
    output logic ce_14m,
    output logic ce_7m,
    output logic ce_3m5,
    output logic ready
);

    localparam logic [SEQ_CNT_W-1:0] STABLE_LAST = SEQ_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [SEQ_CNT_W-1:0] GAP_LAST    = SEQ_CNT_W'(STAGE_GAP - 1);
    localparam logic [SEQ_CNT_W-1:0] SOFT_LAST   = SEQ_CNT_W'(SOFT_CYCLES - 1);

    seq_state_t           state;
    logic [SEQ_CNT_W-1:0] cnt;
    logic [SEQ_CNT_W-1:0] cnt_inc;
    logic                 lock_s;
    logic [2:0]           div;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Saturate rather than wrap so a long stall can never fake a terminal count.
    assign cnt_inc = (cnt == {SEQ_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            rst_mem    <= 1'b1;
            rst_core   <= 1'b1;
            rst_periph <= 1'b1;
            ready      <= 1'b0;
        end else if (state != WAIT_LOCK && !lock_s) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            rst_mem    <= 1'b1;
            rst_core   <= 1'b1;
            rst_periph <= 1'b1;
            ready      <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt        <= '0;
                    rst_mem    <= 1'b1;
                    rst_core   <= 1'b1;
                    rst_periph <= 1'b1;
                    ready      <= 1'b0;
                    if (lock_s) begin
                        state <= STABLE;
                    end
                end
                STABLE: begin
                    if (cnt == STABLE_LAST) begin
                        state   <= REL_MEM;
                        cnt     <= '0;
                        rst_mem <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                REL_MEM: begin
                    if (cnt == GAP_LAST) begin
                        state    <= REL_CORE;
                        cnt      <= '0;
                        rst_core <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                REL_CORE: begin
                    if (cnt == GAP_LAST) begin
                        state      <= RUN;
                        cnt        <= '0;
                        rst_periph <= 1'b0;
                        ready      <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RUN: begin
                    cnt <= '0;
                    if (soft_rst_req) begin
                        state      <= SOFT;
                        rst_core   <= 1'b1;
                        rst_periph <= 1'b1;
                        ready      <= 1'b0;
                    end
                end
                SOFT: begin
                    if (cnt == SOFT_LAST) begin
                        state    <= REL_CORE;
                        cnt      <= '0;
                        rst_core <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state      <= WAIT_LOCK;
                    cnt        <= '0;
                    rst_mem    <= 1'b1;
                    rst_core   <= 1'b1;
                    rst_periph <= 1'b1;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (rst_core) begin
            div <= '0;
        end else begin
            div <= div + 3'd1;
        end
    end

    // Gating keeps the strobes quiet on the edge a soft reset re-asserts rst_core.
    assign ce_14m = ~rst_core & div[0];
    assign ce_7m  = ~rst_core & (div[1:0] == 2'b11);
    assign ce_3m5 = ~rst_core & (div == 3'b111);

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 1024: cycles the synchronized lock must stay high before the first reset release; legal range 2..65535.
REQ-002 Parameter STAGE_GAP, default 16: cycles between successive reset releases; legal range 1..65535.
REQ-003 Parameter SOFT_CYCLES, default 8: core/periph reset hold length for a soft reset; legal range 1..65535.
REQ-004 clk  input  1  28 MHz system clock (PLL output 0); sole clock of the block.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pll_locked  input  1  PLL lock flag; asynchronous to clk.
REQ-007 soft_rst_req  input  1  single-cycle soft reset request, synchronous to clk.
REQ-008 rst_mem  output  1  active-high reset for the memory/SDRAM controller.
REQ-009 rst_core  output  1  active-high reset for the CPU/ULA core.
REQ-010 rst_periph  output  1  active-high reset for peripherals.
REQ-011 ce_14m, ce_7m, ce_3m5  output  1 each  single-cycle clock-enable strobes at clk/2, clk/4 and clk/8.
REQ-012 ready  output  1  high only in state RUN.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; lock_s denotes its output, valid 2 rising edges after the input changes.
REQ-014 The FSM SHALL have states WAIT_LOCK, STABLE, REL_MEM, REL_CORE, RUN, SOFT.
REQ-015 WAIT_LOCK: all three resets high, counter 0; lock_s=1 -> STABLE with counter 0.
REQ-016 STABLE: counter increments each cycle; at counter = LOCK_STABLE_CYCLES-1 -> REL_MEM, counter cleared, rst_mem driven low on that edge.
REQ-017 REL_MEM: after STAGE_GAP cycles -> REL_CORE, rst_core driven low on that edge.
REQ-018 REL_CORE: after STAGE_GAP cycles -> RUN, rst_periph driven low on that edge.
REQ-019 RUN: soft_rst_req=1 -> SOFT, rst_core and rst_periph driven high on that edge; rst_mem stays low.
REQ-020 SOFT: after SOFT_CYCLES cycles -> REL_CORE with rst_core low and rst_periph still high, then per REQ-018.
REQ-021 soft_rst_req SHALL be ignored in every state except RUN.
REQ-022 lock_s=0 in any state other than WAIT_LOCK SHALL force WAIT_LOCK and assert all resets on the next edge; this takes priority over soft_rst_req.
REQ-023 Total latency from a pll_locked rise (lock held) to rst_mem low SHALL be LOCK_STABLE_CYCLES+3 rising edges.
REQ-024 All reset outputs and ready SHALL be registered; no combinational path from inputs.
REQ-025 A 3-bit divider counter SHALL be held at 0 while rst_core is high, then increment every cycle.
REQ-026 Strobe timing: ce_14m high when counter bit0 = 1; ce_7m when bits[1:0] = 3; ce_3m5 when bits[2:0] = 7. The first ce_14m strobe SHALL occur on the 2nd cycle after rst_core falls.
REQ-027 The sequence counter SHALL be 16 bits, SHALL never wrap, and SHALL be cleared on every state change.

Reset
REQ-028 rst=1 SHALL asynchronously force WAIT_LOCK, counters 0, rst_mem/rst_core/rst_periph=1, all strobes=0, ready=0, and synchronizer flops 0.
REQ-029 Release of rst SHALL restart the full sequence from REQ-015; a mid-sequence rst aborts without glitching any reset output low.

Structure
REQ-030 The state enumeration and the parameter default constants SHALL live in the shared package pll_reset_pkg.
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with the same clk/rst ports and a reset value of 0.

Verification (LOCK_STABLE_CYCLES=8, STAGE_GAP=4, SOFT_CYCLES=8)
REQ-032 pll_locked rises at edge 0 and stays high -> rst_mem low at edge 11, rst_core low at edge 15, rst_periph low and ready high at edge 19.
REQ-033 pll_locked drops for 1 cycle in STABLE at counter 5 -> return to WAIT_LOCK; the full 8-cycle stability count restarts; rst_mem is never released early.
REQ-034 soft_rst_req pulses in RUN -> rst_core/rst_periph high for 8 cycles with rst_mem low throughout; then rst_core low, and rst_periph low 4 cycles later.
REQ-035 soft_rst_req and a lock_s fall in the same cycle in RUN -> WAIT_LOCK with all three resets high next edge.
REQ-036 After rst_core falls -> ce_14m period 2, ce_7m period 4, ce_3m5 period 8, first ce_3m5 on the 8th cycle; no strobes while rst_core is high.
REQ-037 rst asserted asynchronously mid REL_MEM -> all resets high immediately; after release the sequence completes at the same edge counts as REQ-032.
